// File: rtl/frogger_game_ctrl.sv
// Frogger game controller: start/cleanup/run/death/win/game-over sequencing,
// lives and saturating score bookkeeping, and Frogger reset pulses.
module frogger_game_ctrl #(
    parameter int unsigned c_WIN_ROW     = 0,
    parameter int unsigned c_START_LIVES = 3,
    parameter int unsigned c_DEATH_TICKS = 25000000,
    parameter int unsigned c_WIN_TICKS   = 12500000,
    parameter int unsigned c_MAX_SCORE   = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic       o_Game_Active,
    output logic       o_Frogger_Reset,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic [2:0] o_State,
    output logic       o_Game_Over
);

    localparam int unsigned CNT_W = 25;
    localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(c_DEATH_TICKS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(c_WIN_TICKS - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(c_START_LIVES);
    localparam logic [6:0]       SCORE_MAX  = 7'(c_MAX_SCORE);
    localparam logic [5:0]       WIN_ROW    = 6'(c_WIN_ROW);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEANUP   = 3'd1,
        RUNNING   = 3'd2,
        DEATH     = 3'd3,
        P1_WINS   = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    state_t           state, next_state;
    logic [1:0]       lives, next_lives;
    logic [6:0]       score, next_score;
    logic [CNT_W-1:0] hold_cnt, next_cnt;
    logic             start_q;
    logic             start_edge;
    logic             game_active, game_over, frogger_reset;
    logic             next_frogger_reset;

    assign start_edge = i_Game_Start & ~start_q;

    // Next-state, bookkeeping and next-output decode
    always_comb begin
        next_state = state;
        next_lives = lives;
        next_score = score;
        next_cnt   = hold_cnt;
        case (state)
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    next_state = CLEANUP;
                    next_lives = LIVES_INIT;
                    next_score = 7'd0;
                end
            end
            CLEANUP: next_state = RUNNING;
            RUNNING: begin
                if (i_Collided) begin
                    if (lives > 2'd1) begin
                        next_lives = lives - 2'd1;
                        next_state = DEATH;
                        next_cnt   = '0;
                    end else begin
                        next_lives = 2'd0;
                        next_state = GAME_OVER;
                    end
                end else if (i_Frogger_Y == WIN_ROW) begin
                    next_score = (score < SCORE_MAX) ? score + 7'd1 : score;
                    next_state = P1_WINS;
                    next_cnt   = '0;
                end
            end
            DEATH: begin
                if (hold_cnt == DEATH_LAST) next_state = RUNNING;
                else                        next_cnt   = hold_cnt + CNT_W'(1);
            end
            P1_WINS: begin
                if (hold_cnt == WIN_LAST) next_state = RUNNING;
                else                      next_cnt   = hold_cnt + CNT_W'(1);
            end
            default: next_state = IDLE;
        endcase

        // Pulse lines up with CLEANUP and with the last cycle of each hold
        next_frogger_reset = (next_state == CLEANUP) ||
                             (next_state == DEATH   && next_cnt == DEATH_LAST) ||
                             (next_state == P1_WINS && next_cnt == WIN_LAST);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= IDLE;
            lives         <= LIVES_INIT;
            score         <= 7'd0;
            hold_cnt      <= '0;
            start_q       <= 1'b0;
            game_active   <= 1'b0;
            game_over     <= 1'b0;
            frogger_reset <= 1'b0;
        end else begin
            state         <= next_state;
            lives         <= next_lives;
            score         <= next_score;
            hold_cnt      <= next_cnt;
            start_q       <= i_Game_Start;
            game_active   <= (next_state == RUNNING);
            game_over     <= (next_state == GAME_OVER);
            frogger_reset <= next_frogger_reset;
        end
    end

    assign o_State         = state;
    assign o_Lives         = lives;
    assign o_Score         = score;
    assign o_Game_Active   = game_active;
    assign o_Game_Over     = game_over;
    assign o_Frogger_Reset = frogger_reset;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Self-checking bench for frogger_game_ctrl: directed scenarios with literal
// expectations, then randomized play checked every cycle against a reference model.
module tb_frogger_game_ctrl;

    localparam int D_TICKS = 4;
    localparam int W_TICKS = 3;
    localparam int START_L = 3;
    localparam int MAX_SC  = 99;
    localparam int WIN_Y   = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       gs;
    logic       col;
    logic [5:0] fy;
    logic       active, fr, gover;
    logic [1:0] lives;
    logic [6:0] score;
    logic [2:0] st;

    frogger_game_ctrl #(
        .c_WIN_ROW    (0),
        .c_START_LIVES(3),
        .c_DEATH_TICKS(4),
        .c_WIN_TICKS  (3),
        .c_MAX_SCORE  (99)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Game_Start   (gs),
        .i_Collided     (col),
        .i_Frogger_Y    (fy),
        .o_Game_Active  (active),
        .o_Frogger_Reset(fr),
        .o_Lives        (lives),
        .o_Score        (score),
        .o_State        (st),
        .o_Game_Over    (gover)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase code, lives, score, cycles of hold left, pulse
    int m_state, m_lives, m_score, m_hold;
    bit m_fr, m_prev;
    bit cmp_en = 1'b0;
    bit fr_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = START_L; m_score = 0; m_hold = 0;
        m_fr = 1'b0; m_prev = 1'b0;
    endtask

    task automatic begin_game();
        m_state = 1; m_lives = START_L; m_score = 0; m_fr = 1'b1;
    endtask

    // One clock of game rules applied to the inputs seen at that edge
    task automatic model_step(input bit g, input bit c, input int y);
        bit start_evt;
        start_evt = g && !m_prev;
        m_prev = g;
        m_fr = 1'b0;
        case (m_state)
            0, 5: if (start_evt) begin_game();
            1: m_state = 2;
            2: begin
                if (c) begin
                    if (m_lives > 1) begin
                        m_lives--; m_state = 3; m_hold = D_TICKS;
                    end else begin
                        m_lives = 0; m_state = 5;
                    end
                end else if (y == WIN_Y) begin
                    m_score = (m_score + 1 > MAX_SC) ? MAX_SC : m_score + 1;
                    m_state = 4; m_hold = W_TICKS;
                end
            end
            default: begin
                m_hold--;
                if (m_hold == 0) m_state = 2;
            end
        endcase
        if ((m_state == 3 || m_state == 4) && m_hold == 1) m_fr = 1'b1;
    endtask

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", int'(st), m_state);
            chk("lives", int'(lives), m_lives);
            chk("score", int'(score), m_score);
            chk("active", int'(active), int'(m_state == 2));
            chk("game_over", int'(gover), int'(m_state == 5));
            chk("frog_reset", int'(fr), int'(m_fr));
            chk("frog_reset_consec", int'(fr && fr_prev), 0);
            fr_prev = fr;
        end
    end

    task automatic step(input bit g, input bit c, input logic [5:0] y);
        @(negedge clk);
        #1;
        gs = g; col = c; fy = y;
        @(posedge clk);
        if (!rst) model_step(g, c, int'(y));
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd5);
    endtask

    task automatic win_round();
        step(1'b0, 1'b0, 6'd0);
        idle(W_TICKS);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        gs = 1'b0; rst = 1'b1;
        #1;
        model_reset();
        chk("rst_state", int'(st), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_fr", int'(fr), 0);
        chk("rst_active", int'(active), 0);
        step(1'b0, 1'b0, 6'd5);
        step(1'b0, 1'b0, 6'd5);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gs = 1'b0; col = 1'b0; fy = 6'd5;
        model_reset();
        #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("reset_state", int'(st), 0);
        chk("reset_lives", int'(lives), 3);
        chk("reset_score", int'(score), 0);

        // Start with button held 10 cycles
        step(1'b1, 1'b0, 6'd5);
        chk("cleanup_state", int'(st), 1);
        chk("cleanup_fr", int'(fr), 1);
        step(1'b1, 1'b0, 6'd5);
        chk("run_state", int'(st), 2);
        chk("run_active", int'(active), 1);
        chk("run_lives", int'(lives), 3);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'd5);
        chk("held_start_state", int'(st), 2);
        chk("held_fr", int'(fr), 0);

        // Death hold
        step(1'b0, 1'b1, 6'd5);
        chk("death_state", int'(st), 3);
        chk("death_lives", int'(lives), 2);
        chk("death_active", int'(active), 0);
        step(1'b0, 1'b1, 6'd0);
        step(1'b1, 1'b0, 6'd0);
        chk("death_c3_fr", int'(fr), 0);
        step(1'b0, 1'b0, 6'd0);
        chk("death_end_fr", int'(fr), 1);
        step(1'b0, 1'b0, 6'd5);
        chk("death_back_run", int'(st), 2);

        // Win, then tie
        step(1'b0, 1'b0, 6'd0);
        chk("win_state", int'(st), 4);
        chk("win_score", int'(score), 1);
        step(1'b0, 1'b0, 6'd5);
        step(1'b0, 1'b0, 6'd5);
        chk("win_end_fr", int'(fr), 1);
        step(1'b0, 1'b0, 6'd5);
        chk("win_back_run", int'(st), 2);
        step(1'b0, 1'b1, 6'd0);
        chk("tie_state", int'(st), 3);
        chk("tie_score", int'(score), 1);
        chk("tie_lives", int'(lives), 1);
        idle(D_TICKS);

        // Game over and restart
        step(1'b0, 1'b1, 6'd5);
        chk("go_state", int'(st), 5);
        chk("go_lives", int'(lives), 0);
        chk("go_flag", int'(gover), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'd0);
        chk("go_hold_state", int'(st), 5);
        chk("go_hold_score", int'(score), 1);
        step(1'b1, 1'b0, 6'd5);
        chk("restart_state", int'(st), 1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(score), 0);
        idle(1);

        // Saturation
        for (int i = 0; i < 98; i++) win_round();
        chk("sat_98", int'(score), 98);
        step(1'b0, 1'b0, 6'd0);
        chk("sat_99", int'(score), 99);
        idle(W_TICKS);
        step(1'b0, 1'b0, 6'd0);
        chk("sat_99_hold", int'(score), 99);
        idle(W_TICKS);

        // Async reset in the middle of a death hold
        step(1'b0, 1'b1, 6'd5);
        step(1'b0, 1'b0, 6'd5);
        async_reset();
        idle(6);
        chk("post_rst_idle", int'(st), 0);

        // Randomized play
        begin
            bit g = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                bit c;
                logic [5:0] y;
                if ($urandom_range(0, 19) == 0) g = ~g;
                c = ($urandom_range(0, 9) == 0);
                y = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                if ($urandom_range(0, 599) == 0) async_reset();
                else step(g, c, y);
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frogger_game_ctrl.md
FROGGER_GAME_CTRL -- requirements
Module: frogger_game_ctrl

Interface
REQ-001 The module SHALL provide the following parameters:
- c_WIN_ROW, default 0: Frogger tile row that counts as reaching home.
- c_START_LIVES, default 3: lives loaded at game start, range 1..3.
- c_DEATH_TICKS, default 25000000: hold cycles in DEATH.
- c_WIN_TICKS, default 12500000: hold cycles in P1_WINS.
- c_MAX_SCORE, default 99: score saturation value.

REQ-002 The module SHALL provide the following ports, clock and reset first:
- i_Clk, in, 1: system clock.
- i_Rst, in, 1: reset, asynchronous, active-high.
- i_Game_Start, in, 1: start button level, already debounced.
- i_Collided, in, 1: Frogger/car collision level.
- i_Frogger_Y, in, 6: Frogger tile row.
- o_Game_Active, out, 1: high only in RUNNING; enables Frogger movement.
- o_Frogger_Reset, out, 1: one-cycle pulse that returns Frogger to its start tile.
- o_Lives, out, 2: remaining lives.
- o_Score, out, 7: home arrivals, binary, feeds the 7-segment block.
- o_State, out, 3: encoded FSM state, for debug.
- o_Game_Over, out, 1: high in GAME_OVER.

Function
REQ-003 The FSM SHALL have six states with these encodings: IDLE=0, CLEANUP=1, RUNNING=2, DEATH=3, P1_WINS=4, GAME_OVER=5; codes 6 and 7 SHALL go to IDLE on the next clock.
REQ-004 Start SHALL be detected on the rising edge of i_Game_Start, using a one-flop history register; a held button SHALL produce exactly one start event.
REQ-005 In IDLE, a start edge SHALL cause a transition to CLEANUP on the next clock.
REQ-006 CLEANUP SHALL last exactly one cycle:
- load o_Lives=c_START_LIVES;
- clear o_Score to 0;
- assert o_Frogger_Reset;
- go to RUNNING.
REQ-007 In RUNNING with i_Collided=1:
- if o_Lives>1: decrement o_Lives and go to DEATH;
- if o_Lives==1: set o_Lives=0 and go to GAME_OVER.
REQ-008 In RUNNING with i_Collided=0 and i_Frogger_Y==c_WIN_ROW, the FSM SHALL increment o_Score, saturating at c_MAX_SCORE, and go to P1_WINS.
REQ-009 If a collision and the win row occur in the same cycle, the collision SHALL take priority and the score SHALL be unchanged.
REQ-010 On entry to DEATH or P1_WINS, a 25-bit hold counter SHALL load 0.
- The counter SHALL increment once per cycle.
- When it reaches c_DEATH_TICKS-1 (DEATH) or c_WIN_TICKS-1 (P1_WINS), o_Frogger_Reset SHALL pulse for that one cycle and the FSM SHALL return to RUNNING.
REQ-011 In DEATH and P1_WINS, i_Collided, i_Frogger_Y and start edges SHALL be ignored.
REQ-012 In GAME_OVER, lives and score SHALL hold; a start edge SHALL go to CLEANUP.
REQ-013 A start edge in RUNNING, DEATH or P1_WINS SHALL be ignored.
REQ-014 All outputs SHALL be registered; o_Game_Active and o_Game_Over SHALL change in the same cycle as o_State.
REQ-015 Decision latency SHALL be one clock from the input sample to the state/output change.
REQ-016 o_Frogger_Reset SHALL never be high for two consecutive cycles.

Reset
REQ-017 On i_Rst=1, the block SHALL immediately, without waiting for a clock, enter IDLE and set:
- o_Lives=c_START_LIVES, o_Score=0;
- o_Game_Active=0, o_Frogger_Reset=0, o_Game_Over=0;
- hold counter=0, start history=0.
REQ-018 Reset asserted mid-hold or mid-game SHALL abort the hold with no o_Frogger_Reset pulse; after release, the block SHALL wait for a new start edge.

Verification
REQ-019 Run the bench with c_DEATH_TICKS=4 and c_WIN_TICKS=3, and cover these scenarios:
- Start: from reset, hold i_Game_Start high for 10 cycles -> one CLEANUP cycle, one o_Frogger_Reset pulse, RUNNING, o_Lives=3, o_Score=0, o_Game_Active=1.
- Death: in RUNNING, pulse i_Collided -> next clock DEATH, o_Lives=2, o_Game_Active=0; 4 cycles later o_Frogger_Reset pulses, then RUNNING.
- Game over: three collisions -> o_Lives=0, GAME_OVER, o_Game_Over=1; further collisions leave the state unchanged; a start edge -> CLEANUP, o_Lives=3, o_Score=0.
- Win and tie: i_Frogger_Y=0 -> P1_WINS, o_Score+1; after 3 cycles a reset pulse, then RUNNING. i_Frogger_Y=0 together with i_Collided=1 -> DEATH, score unchanged.
- Saturation: preload 98 wins -> score 98; two more wins -> 99, 99.
- Async reset: assert i_Rst mid-DEATH, between clock edges -> immediate IDLE, o_Lives=3, no o_Frogger_Reset pulse.
